// File: rtl/iob_iob2wishbone_burst.sv
// rtl/iob_iob2wishbone_burst.sv - IOb master to Wishbone B3 master bridge with linear bursts, watchdog and error return
module iob_iob2wishbone_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                iob_valid,
  input  logic [ADDR_W-1:0]   iob_addr,
  input  logic [DATA_W-1:0]   iob_wdata,
  input  logic [DATA_W/8-1:0] iob_wstrb,
  input  logic [LEN_W-1:0]    iob_len,
  output logic [DATA_W-1:0]   iob_rdata,
  output logic                iob_ready,
  output logic                iob_err,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic [2:0]          wb_cti_o,
  output logic [1:0]          wb_bte_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);

  localparam int BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADR_STEP = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] ADR_MASK = ~(ADDR_W'(BYTES - 1));
  // Last watchdog value before it would reach all ones: the abort fires on
  // the edge that ends the (2^TIMEOUT_W-1)-th idle cycle.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT_NEXT = 2'd2} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LEN_W-1:0]     left;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 timeout;
  logic                 beat_done;
  logic                 beat_fail;
  logic                 cyc_nxt;
  logic                 stb_nxt;
  logic                 ready_nxt;
  logic                 err_nxt;

  assign wb_bte_o = 2'b00;
  assign timeout  = (wdog == WD_LAST);

  // Slave error beats ack; a slave ack beats the watchdog; a fresh request beats the watchdog while paused.
  assign beat_done = (state == ACCESS) && wb_ack_i && !wb_err_i;
  assign beat_fail = ((state == ACCESS) && (wb_err_i || (!wb_ack_i && timeout))) ||
                     ((state == WAIT_NEXT) && timeout && !iob_valid);

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (iob_valid) state_nxt = ACCESS;
      ACCESS: begin
        if (beat_fail)      state_nxt = IDLE;
        else if (beat_done) state_nxt = (left == '0) ? IDLE : WAIT_NEXT;
      end
      WAIT_NEXT: begin
        if (iob_valid)      state_nxt = ACCESS;
        else if (timeout)   state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode, registered below so every bus-facing signal comes from a flop
  always_comb begin
    cyc_nxt   = (state_nxt != IDLE);
    stb_nxt   = (state_nxt == ACCESS);
    ready_nxt = beat_done || beat_fail;
    err_nxt   = beat_fail;
  end

  // Registered handshake outputs
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      iob_ready <= 1'b0;
      iob_err   <= 1'b0;
    end else begin
      wb_cyc_o  <= cyc_nxt;
      wb_stb_o  <= stb_nxt;
      iob_ready <= ready_nxt;
      iob_err   <= err_nxt;
    end
  end

  // Address, data, select, cycle type and beat counter
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wb_adr_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_dat_o  <= '0;
      wb_cti_o  <= CTI_CLASSIC;
      iob_rdata <= '0;
      left      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iob_valid) begin
            wb_adr_o <= iob_addr & ADR_MASK;
            wb_we_o  <= |iob_wstrb;
            wb_sel_o <= (|iob_wstrb) ? iob_wstrb : '1;
            wb_dat_o <= iob_wdata;
            left     <= iob_len;
            wb_cti_o <= (iob_len == '0) ? CTI_CLASSIC : CTI_INCR;
          end
        end
        ACCESS: begin
          if (beat_done) begin
            if (!wb_we_o) iob_rdata <= wb_dat_i;
            if (left != '0) begin
              wb_adr_o <= wb_adr_o + ADR_STEP;
              left     <= left - LEN_W'(1);
            end
          end
        end
        WAIT_NEXT: begin
          if (iob_valid) begin
            wb_dat_o <= iob_wdata;
            if (wb_we_o) wb_sel_o <= iob_wstrb;
            wb_cti_o <= (left == '0) ? CTI_END : CTI_INCR;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus watchdog: restarts on every entry to an active state, counts while there
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)                                 wdog <= '0;
    else if (state == IDLE || state_nxt != state) wdog <= '0;
    else                                        wdog <= wdog + TIMEOUT_W'(1);
  end

endmodule

// File: tb/tb_iob_iob2wishbone_burst.sv
// tb/tb_iob_iob2wishbone_burst.sv - randomized self-checking bench for iob_iob2wishbone_burst
module tb_iob_iob2wishbone_burst;

  localparam int TW = 4;
  localparam int WD_CYCLES = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        arst_i;
  logic        iob_valid;
  logic [31:0] iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic [3:0]  iob_len;
  logic [31:0] iob_rdata;
  logic        iob_ready;
  logic        iob_err;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  strb_plan[$];
  logic [31:0] rdata_plan[$];

  iob_iob2wishbone_burst #(.ADDR_W(32), .DATA_W(32), .LEN_W(4), .TIMEOUT_W(TW)) dut (
    .clk_i(clk), .arst_i(arst_i),
    .iob_valid(iob_valid), .iob_addr(iob_addr), .iob_wdata(iob_wdata),
    .iob_wstrb(iob_wstrb), .iob_len(iob_len), .iob_rdata(iob_rdata),
    .iob_ready(iob_ready), .iob_err(iob_err),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One burst as master and slave. Expected bus values come from the burst rules:
  // beat b sits at aligned_start + 4*b, cti is classic for single beats, else
  // incrementing until the final beat which is end-of-burst.
  task automatic do_burst(input logic [31:0] addr, input int len, input bit wr,
                          input int err_beat, input int max_dly, input int max_pause);
    logic [31:0] base;
    logic [31:0] exp_adr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [2:0]  exp_cti;
    bit          fail;
    bit          stop;
    stop = 1'b0;
    base = addr & 32'hFFFF_FFFC;
    for (int b = 0; b <= len && !stop; b++) begin
      if (strb_plan.size() > 0) strb = strb_plan.pop_front();
      else                      strb = wr ? 4'($urandom_range(1, 15)) : 4'h0;
      wd = $urandom;
      iob_valid = 1'b1;
      iob_wstrb = strb;
      iob_wdata = wd;
      iob_addr  = (b == 0) ? addr : 32'($urandom);
      iob_len   = (b == 0) ? 4'(len) : 4'($urandom);
      step();
      iob_valid = 1'b0;
      exp_adr = base + 32'(4 * b);
      exp_cti = (len == 0) ? 3'b000 : ((b == len) ? 3'b111 : 3'b010);
      check("cyc_beat", 64'(wb_cyc_o), 64'(1));
      check("stb_beat", 64'(wb_stb_o), 64'(1));
      check("adr", 64'(wb_adr_o), 64'(exp_adr));
      check("we", 64'(wb_we_o), 64'(wr));
      check("sel", 64'(wb_sel_o), 64'(wr ? strb : 4'hF));
      check("cti", 64'(wb_cti_o), 64'(exp_cti));
      check("bte", 64'(wb_bte_o), 64'(0));
      if (wr) check("dat_o", 64'(wb_dat_o), 64'(wd));
      check("ready_early", 64'(iob_ready), 64'(0));
      repeat ($urandom_range(0, max_dly)) begin
        step();
        check("stb_hold", 64'(wb_stb_o), 64'(1));
        check("ready_wait", 64'(iob_ready), 64'(0));
      end
      fail = (b == err_beat);
      rd = (rdata_plan.size() > 0) ? rdata_plan.pop_front() : 32'($urandom);
      wb_dat_i = rd;
      wb_err_i = fail;
      wb_ack_i = fail ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'($urandom);
      check("ready", 64'(iob_ready), 64'(1));
      check("err", 64'(iob_err), 64'(fail));
      if (!wr && !fail) check("rdata", 64'(iob_rdata), 64'(rd));
      check("stb_drop", 64'(wb_stb_o), 64'(0));
      check("cyc_after", 64'(wb_cyc_o), 64'((b < len) && !fail));
      if (fail) stop = 1'b1;
      else if (b < len) begin
        repeat ($urandom_range(0, max_pause)) begin
          step();
          check("cyc_pause", 64'(wb_cyc_o), 64'(1));
          check("stb_pause", 64'(wb_stb_o), 64'(0));
          check("ready_pause", 64'(iob_ready), 64'(0));
        end
      end
    end
    step();
    check("ready_end", 64'(iob_ready), 64'(0));
    check("cyc_end", 64'(wb_cyc_o), 64'(0));
  endtask

  // Starts a read burst and returns once its first strobe is visible
  task automatic start_read(input logic [31:0] addr, input int len);
    iob_valid = 1'b1;
    iob_addr  = addr;
    iob_wstrb = 4'h0;
    iob_len   = 4'(len);
    step();
    iob_valid = 1'b0;
  endtask

  task automatic ack_beat();
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
  endtask

  // Counts edges until an iob_ready pulse, bounded
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!iob_ready && n < 60);
  endtask

  initial begin
    int n;
    arst_i = 1'b1;
    iob_valid = 1'b0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0; iob_len = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", 64'(wb_cyc_o), 64'(0));
    check("rst_stb", 64'(wb_stb_o), 64'(0));
    check("rst_ready", 64'(iob_ready), 64'(0));
    check("rst_err", 64'(iob_err), 64'(0));
    check("rst_adr", 64'(wb_adr_o), 64'(0));
    check("rst_sel", 64'(wb_sel_o), 64'(0));
    check("rst_cti", 64'(wb_cti_o), 64'(0));
    check("rst_rdata", 64'(iob_rdata), 64'(0));
    arst_i = 1'b0;
    step();

    // Single classic read from an unaligned address
    rdata_plan.push_back(32'hDEADBEEF);
    do_burst(32'h0000_1003, 0, 1'b0, -1, 1, 0);

    // Four-beat write burst with a changing byte-enable pattern
    strb_plan = '{4'hF, 4'h3, 4'hC, 4'hF};
    do_burst(32'h0000_2000, 3, 1'b1, -1, 2, 2);

    // Slave error on the second beat of a 4-beat read, then a fresh request
    do_burst(32'h0000_3000, 3, 1'b0, 1, 1, 1);
    do_burst(32'h0000_4444, 1, 1'b0, -1, 1, 1);

    // Address wrap across the top of the space
    do_burst(32'hFFFF_FFFC, 1, 1'b0, -1, 1, 1);

    // Watchdog while the slave never answers
    start_read(32'h0000_5000, 0);
    wait_ready(n);
    check("wd_access_cycles", 64'(n), 64'(WD_CYCLES));
    check("wd_access_err", 64'(iob_err), 64'(1));
    check("wd_access_cyc", 64'(wb_cyc_o), 64'(0));
    step();

    // Watchdog while the master pauses mid-burst
    start_read(32'h0000_6000, 1);
    ack_beat();
    check("wd_wait_first", 64'(iob_ready), 64'(1));
    wait_ready(n);
    check("wd_wait_cycles", 64'(n), 64'(WD_CYCLES));
    check("wd_wait_err", 64'(iob_err), 64'(1));
    check("wd_wait_cyc", 64'(wb_cyc_o), 64'(0));
    repeat (5) step();
    check("wd_wait_idle", 64'(wb_cyc_o), 64'(0));

    // A request arriving in the very cycle the watchdog expires still continues the burst
    start_read(32'h0000_7000, 1);
    ack_beat();
    repeat (WD_CYCLES - 1) step();
    check("late_cyc_held", 64'(wb_cyc_o), 64'(1));
    iob_valid = 1'b1;
    step();
    iob_valid = 1'b0;
    check("late_stb", 64'(wb_stb_o), 64'(1));
    check("late_err", 64'(iob_err), 64'(0));
    check("late_adr", 64'(wb_adr_o), 64'(32'h0000_7004));
    check("late_cti", 64'(wb_cti_o), 64'(3'b111));
    ack_beat();
    check("late_ready", 64'(iob_ready), 64'(1));
    check("late_done_err", 64'(iob_err), 64'(0));
    step();

    // Asynchronous reset in the middle of an access
    start_read(32'h0000_8000, 2);
    arst_i = 1'b1;
    #1;
    check("arst_cyc", 64'(wb_cyc_o), 64'(0));
    check("arst_stb", 64'(wb_stb_o), 64'(0));
    check("arst_ready", 64'(iob_ready), 64'(0));
    check("arst_err", 64'(iob_err), 64'(0));
    @(negedge clk);
    arst_i = 1'b0;
    step();
    do_burst(32'h0000_9000, 2, 1'b1, -1, 1, 1);

    // Randomized bursts
    for (int t = 0; t < 40; t++) begin
      int len;
      len = $urandom_range(0, 15);
      do_burst(32'($urandom), len, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1, 3, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: bench did not finish, checks=%0d", n_checks);
    $fatal(1, "bench timeout");
  end

endmodule
